// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared TAP state encodings and instruction field positions
package jtag_pkg;

    localparam int IR_WIDTH = 9;

    // Instruction doubles as the memory block address
    localparam int SEL_BIT = 8;
    localparam int WR_MSB  = 7;
    localparam int WR_LSB  = 4;
    localparam int RD_MSB  = 3;
    localparam int RD_LSB  = 0;

    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_t;

endpackage

// File: rtl/jtag_tap_controller_if.sv
// rtl/jtag_tap_controller_if.sv - TAP pins and memory-DR side signals
interface jtag_tap_controller_if #(
    parameter int IR_WIDTH = jtag_pkg::IR_WIDTH
);
    logic                iTMS;
    logic                iTDI;
    logic                iDR_TDO;
    logic                oSTATE_CDR;
    logic                oSTATE_SDR;
    logic                oSTATE_UDR;
    logic                oSTATE_TLR;
    logic [3:0]          oSTATE;
    logic [IR_WIDTH-1:0] oIR;
    logic                oSEL_MEM;
    logic                oTDO;
    logic                oTDO_EN;

    modport master (
        output iTMS, iTDI, iDR_TDO,
        input  oSTATE_CDR, oSTATE_SDR, oSTATE_UDR, oSTATE_TLR, oSTATE,
        input  oIR, oSEL_MEM, oTDO, oTDO_EN
    );

    modport slave (
        input  iTMS, iTDI, iDR_TDO,
        output oSTATE_CDR, oSTATE_SDR, oSTATE_UDR, oSTATE_TLR, oSTATE,
        output oIR, oSEL_MEM, oTDO, oTDO_EN
    );
endinterface

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - IEEE 1149.1 16-state TAP controller with state decodes
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst_n,
    input  logic       tms,
    output tap_state_t state,
    output logic       st_tlr,
    output logic       st_cdr,
    output logic       st_sdr,
    output logic       st_udr,
    output logic       st_cir,
    output logic       st_sir,
    output logic       st_uir
);
    tap_state_t state_next;

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) state <= TLR;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            TLR:      state_next = tms ? TLR    : RTI;
            RTI:      state_next = tms ? SEL_DR : RTI;
            SEL_DR:   state_next = tms ? SEL_IR : CAP_DR;
            CAP_DR:   state_next = tms ? EX1_DR : SH_DR;
            SH_DR:    state_next = tms ? EX1_DR : SH_DR;
            EX1_DR:   state_next = tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: state_next = tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   state_next = tms ? UPD_DR : SH_DR;
            UPD_DR:   state_next = tms ? SEL_DR : RTI;
            SEL_IR:   state_next = tms ? TLR    : CAP_IR;
            CAP_IR:   state_next = tms ? EX1_IR : SH_IR;
            SH_IR:    state_next = tms ? EX1_IR : SH_IR;
            EX1_IR:   state_next = tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: state_next = tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   state_next = tms ? UPD_IR : SH_IR;
            UPD_IR:   state_next = tms ? SEL_DR : RTI;
            default:  state_next = TLR;
        endcase
    end

    // Strobes last the whole cycle; consumers act on the edge leaving the state
    always_comb begin
        st_tlr = (state == TLR);
        st_cdr = (state == CAP_DR);
        st_sdr = (state == SH_DR);
        st_udr = (state == UPD_DR);
        st_cir = (state == CAP_IR);
        st_sir = (state == SH_IR);
        st_uir = (state == UPD_IR);
    end

endmodule

// File: rtl/jtag_tap_controller.sv
// rtl/jtag_tap_controller.sv - TAP controller, instruction register, bypass and TDO mux
module jtag_tap_controller
    import jtag_pkg::*;
#(
    parameter int                                 IR_WIDTH   = jtag_pkg::IR_WIDTH,
    parameter logic [IR_WIDTH-1:0]                IR_RESET   = 9'h1FF,
    parameter logic [IR_WIDTH-1:0]                IR_CAPTURE = 9'h001
) (
    input  logic                  iTCK,
    input  logic                  iTRST_N,
    jtag_tap_controller_if.slave  bus
);
    tap_state_t          state;
    logic                st_tlr, st_cdr, st_sdr, st_udr;
    logic                st_cir, st_sir, st_uir;
    logic [IR_WIDTH-1:0] ir_sr;
    logic [IR_WIDTH-1:0] ir;
    logic                bypass;
    logic                tdo;
    logic                tdo_en;
    logic                sel_mem;

    jtag_tap_fsm u_fsm (
        .tck    (iTCK),
        .trst_n (iTRST_N),
        .tms    (bus.iTMS),
        .state  (state),
        .st_tlr (st_tlr),
        .st_cdr (st_cdr),
        .st_sdr (st_sdr),
        .st_udr (st_udr),
        .st_cir (st_cir),
        .st_sir (st_sir),
        .st_uir (st_uir)
    );

    assign sel_mem = ir[IR_WIDTH-1];

    // ir only moves in Update-IR or TLR, so the memory address is stable while shifting
    always_ff @(posedge iTCK or negedge iTRST_N) begin
        if (!iTRST_N) begin
            ir_sr  <= '0;
            ir     <= IR_RESET;
            bypass <= 1'b0;
        end else begin
            if (st_cir)
                ir_sr <= IR_CAPTURE;
            else if (st_sir)
                ir_sr <= {bus.iTDI, ir_sr[IR_WIDTH-1:1]};

            if (st_uir)
                ir <= ir_sr;
            else if (st_tlr)
                ir <= IR_RESET;

            if (st_cdr)
                bypass <= 1'b0;
            else if (st_sdr && !sel_mem)
                bypass <= bus.iTDI;
        end
    end

    // Falling-edge launch gives the receiver half a cycle of setup before its rising edge
    always_ff @(negedge iTCK or negedge iTRST_N) begin
        if (!iTRST_N) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo_en <= st_sir || st_sdr;
            if (st_sir)
                tdo <= ir_sr[0];
            else if (st_sdr)
                tdo <= sel_mem ? bus.iDR_TDO : bypass;
        end
    end

    assign bus.oSTATE_CDR = st_cdr;
    assign bus.oSTATE_SDR = st_sdr;
    assign bus.oSTATE_UDR = st_udr;
    assign bus.oSTATE_TLR = st_tlr;
    assign bus.oSTATE     = state;
    assign bus.oIR        = ir;
    assign bus.oSEL_MEM   = sel_mem;
    assign bus.oTDO       = tdo;
    assign bus.oTDO_EN    = tdo_en;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// tb/tb_jtag_tap_controller.sv - directed vector bench for jtag_tap_controller
module tb_jtag_tap_controller;

    logic tck    = 1'b0;
    logic trst_n = 1'b0;

    jtag_tap_controller_if bus ();

    jtag_tap_controller dut (
        .iTCK    (tck),
        .iTRST_N (trst_n),
        .bus     (bus)
    );

    always #10 tck = ~tck;

    int   n_vec = 0;
    int   n_bad = 0;
    logic pre_tdo, pre_en;

    typedef struct {
        logic       tms;
        logic       tdi;
        logic [1:0] chk;     // 0: state/ir only, 1: +tdo_en, 2: +tdo
        logic       exp_tdo;
        logic       exp_en;
        logic [3:0] exp_st;
        logic [8:0] exp_ir;
    } vec_t;

    typedef struct {
        int         len;
        logic [7:0] bits;
        logic [3:0] st;
    } path_t;

    vec_t  vt[$];
    path_t paths[16];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at posedge+2; records TDO seen during the current state, returns at next posedge+2
    task automatic step(input logic tms, input logic tdi, input logic drt);
        bus.iTMS    = tms;
        bus.iTDI    = tdi;
        bus.iDR_TDO = drt;
        @(negedge tck);
        #2;
        pre_tdo = bus.oTDO;
        pre_en  = bus.oTDO_EN;
        @(posedge tck);
        #2;
    endtask

    task automatic ir_scan(input logic [8:0] val, input logic [8:0] prev);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("scan_in_shir", bus.oSTATE, 4'hA);
        for (int i = 0; i < 9; i++) begin
            step(i == 8, val[i], 1'b0);
            chk("scan_ir_hold", bus.oIR, prev);
        end
        step(1'b1, 1'b0, 1'b0);
        chk("scan_updir_state", bus.oSTATE, 4'hD);
        chk("scan_updir_ir_hold", bus.oIR, prev);
        step(1'b0, 1'b0, 1'b0);
        chk("scan_ir_loaded", bus.oIR, val);
        chk("scan_rti", bus.oSTATE, 4'hC);
    endtask

    initial begin
        logic [8:0] pat;
        logic [3:0] byp_in, byp_out;
        int         n_cdr, n_sdr, n_udr;
        logic       drt;

        bus.iTMS = 1'b0; bus.iTDI = 1'b0; bus.iDR_TDO = 1'b0;

        repeat (2) @(posedge tck);
        #2;
        chk("rst_state", bus.oSTATE, 4'hF);
        chk("rst_ir", bus.oIR, 9'h1FF);
        chk("rst_tdo_en", bus.oTDO_EN, 1'b0);
        chk("rst_tdo", bus.oTDO, 1'b0);
        chk("rst_tlr", bus.oSTATE_TLR, 1'b1);
        trst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("tlr_to_rti", bus.oSTATE, 4'hC);

        // Asynchronous pulse between edges
        #5 trst_n = 1'b0;
        #1;
        chk("async_state", bus.oSTATE, 4'hF);
        chk("async_ir", bus.oIR, 9'h1FF);
        chk("async_tdo_en", bus.oTDO_EN, 1'b0);
        #1 trst_n = 1'b1;
        bus.iTMS = 1'b0;
        @(posedge tck);
        #2;
        chk("async_then_rti", bus.oSTATE, 4'hC);

        // IR scan of 9'h19D as a vector table
        pat = 9'h19D;
        vt.push_back('{1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 4'h7, 9'h1FF});
        vt.push_back('{1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 4'h4, 9'h1FF});
        vt.push_back('{1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 4'hE, 9'h1FF});
        vt.push_back('{1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 4'hA, 9'h1FF});
        for (int i = 0; i < 9; i++)
            vt.push_back('{(i == 8), pat[i], 2'd2, (i == 0), 1'b1,
                           (i == 8) ? 4'h9 : 4'hA, 9'h1FF});
        vt.push_back('{1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 4'hD, 9'h1FF});
        vt.push_back('{1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 4'hC, 9'h19D});

        foreach (vt[k]) begin
            step(vt[k].tms, vt[k].tdi, 1'b0);
            if (vt[k].chk != 2'd0) chk($sformatf("v%0d_tdo_en", k), pre_en, vt[k].exp_en);
            if (vt[k].chk == 2'd2) chk($sformatf("v%0d_tdo", k), pre_tdo, vt[k].exp_tdo);
            chk($sformatf("v%0d_state", k), bus.oSTATE, vt[k].exp_st);
            chk($sformatf("v%0d_ir", k), bus.oIR, vt[k].exp_ir);
        end
        chk("sel_mem_19d", bus.oSEL_MEM, 1'b1);

        // DR pass: count strobe cycles, TDO follows iDR_TDO
        n_cdr = 0; n_sdr = 0; n_udr = 0;
        for (int i = 0; i < 38; i++) begin
            logic tms_i;
            tms_i = (i == 0) || (i == 35) || (i == 36);
            drt   = i[0] ^ i[2];
            step(tms_i, 1'b0, drt);
            if (bus.oSTATE_CDR) n_cdr++;
            if (bus.oSTATE_SDR) n_sdr++;
            if (bus.oSTATE_UDR) n_udr++;
            if (i >= 3 && i <= 35) begin
                chk($sformatf("dr_tdo_%0d", i), pre_tdo, drt);
                chk($sformatf("dr_en_%0d", i), pre_en, 1'b1);
            end
        end
        chk("cdr_cycles", n_cdr, 16'd1);
        chk("sdr_cycles", n_sdr, 16'd33);
        chk("udr_cycles", n_udr, 16'd1);
        chk("dr_end_rti", bus.oSTATE, 4'hC);
        chk("dr_ir_kept", bus.oIR, 9'h19D);

        // Bypass: one-bit delay, iDR_TDO ignored
        ir_scan(9'h0FF, 9'h19D);
        chk("sel_mem_0ff", bus.oSEL_MEM, 1'b0);
        byp_in  = 4'b1101;
        byp_out = 4'b1010;
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, byp_in[i], 1'b1);
            chk($sformatf("bypass_tdo_%0d", i), pre_tdo, byp_out[i]);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("bypass_end_rti", bus.oSTATE, 4'hC);

        // Forced reset from Pause-DR
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("in_pausedr", bus.oSTATE, 4'h3);
        repeat (5) step(1'b1, 1'b0, 1'b0);
        chk("forced_tlr", bus.oSTATE, 4'hF);
        step(1'b1, 1'b0, 1'b0);
        chk("forced_tlr_ir", bus.oIR, 9'h1FF);

        // Five TMS=1 edges from every state
        paths[0]  = '{0, 8'b0,        4'hF};
        paths[1]  = '{1, 8'b0,        4'hC};
        paths[2]  = '{2, 8'b10,       4'h7};
        paths[3]  = '{3, 8'b010,      4'h6};
        paths[4]  = '{4, 8'b0010,     4'h2};
        paths[5]  = '{4, 8'b1010,     4'h1};
        paths[6]  = '{5, 8'b01010,    4'h3};
        paths[7]  = '{6, 8'b101010,   4'h0};
        paths[8]  = '{5, 8'b11010,    4'h5};
        paths[9]  = '{3, 8'b110,      4'h4};
        paths[10] = '{4, 8'b0110,     4'hE};
        paths[11] = '{5, 8'b00110,    4'hA};
        paths[12] = '{5, 8'b10110,    4'h9};
        paths[13] = '{6, 8'b010110,   4'hB};
        paths[14] = '{7, 8'b1010110,  4'h8};
        paths[15] = '{6, 8'b110110,   4'hD};
        for (int s = 0; s < 16; s++) begin
            for (int b = 0; b < paths[s].len; b++)
                step(paths[s].bits[b], 1'b0, 1'b0);
            chk($sformatf("reach_%0h", paths[s].st), bus.oSTATE, paths[s].st);
            repeat (5) step(1'b1, 1'b0, 1'b0);
            chk($sformatf("tlr_from_%0h", paths[s].st), bus.oSTATE, 4'hF);
        end

        // Reset in the middle of an IR shift
        step(1'b0, 1'b0, 1'b0);
        chk("pre_abort_ir", bus.oIR, 9'h1FF);
        ir_scan(9'h19D, 9'h1FF);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        chk("abort_in_shir", bus.oSTATE, 4'hA);
        #3 trst_n = 1'b0;
        #1;
        chk("abort_state", bus.oSTATE, 4'hF);
        chk("abort_ir", bus.oIR, 9'h1FF);
        chk("abort_tdo_en", bus.oTDO_EN, 1'b0);
        #1 trst_n = 1'b1;
        bus.iTMS = 1'b0;
        @(posedge tck);
        #2;
        chk("abort_then_rti", bus.oSTATE, 4'hC);
        ir_scan(9'h0A5, 9'h1FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
